// File: rtl/dehaze_frame_sched.sv
// Frame scheduler for the dark-channel stage: raster walk of the frame buffer,
// latency-matched valid/coordinate/framing strobes. Optional feature: DEHAZE_ATMOS_TRACK_EN.
module dehaze_frame_sched #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int AW      = 19,
    parameter int MEM_LAT = 1,
    parameter int DC_LAT  = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [23:0]   mem_rdata,
    output logic [23:0]   picture_data,
    input  logic [7:0]    dark_in,
    output logic          dark_valid,
    output logic [9:0]    dark_x,
    output logic [8:0]    dark_y,
    output logic          dark_sof,
    output logic          dark_eol,
    output logic          dark_eof,
    output logic          busy,
    output logic          done,
    output logic [7:0]    atm_dark,
    output logic [AW-1:0] atm_addr
);

    localparam int            PL       = MEM_LAT + 1 + DC_LAT;
    localparam logic [AW-1:0] LAST_IDX = AW'(H_ACT * V_ACT - 1);
    localparam logic [AW-1:0] H_AW     = AW'(H_ACT);
    localparam logic [9:0]    X_LAST   = 10'(H_ACT - 1);
    localparam logic [8:0]    Y_LAST   = 9'(V_ACT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] rd_idx;
    logic [PL-1:0] vp;
    logic          start_ok;
    logic          kill;
    logic          rd_fire;

    assign start_ok = (state == IDLE) && start && !abort;
    assign kill     = (state != IDLE) && abort;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN ends in the cycle the last dark pixel is presented, so done follows it directly.
    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                rd_fire = !hold;
                if (rd_fire && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (vp[PL-2:0] == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    assign mem_rd_en = rd_fire;
    assign mem_addr  = rd_idx;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_idx <= '0;
        end else if (kill || start_ok) begin
            rd_idx <= '0;
        end else if (rd_fire && (rd_idx != LAST_IDX)) begin
            rd_idx <= rd_idx + AW'(1);
        end
    end

    // Fixed-latency valid pipe: vp[MEM_LAT-1] marks mem_rdata valid, vp[MEM_LAT] picture_data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vp           <= '0;
            picture_data <= '0;
        end else if (kill) begin
            vp           <= '0;
            picture_data <= '0;
        end else begin
            vp           <= {vp[PL-2:0], rd_fire};
            picture_data <= vp[MEM_LAT-1] ? mem_rdata : 24'd0;
        end
    end

    assign dark_valid = vp[PL-1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dark_x <= '0;
            dark_y <= '0;
        end else if (kill || start_ok) begin
            dark_x <= '0;
            dark_y <= '0;
        end else if (dark_valid) begin
            if (dark_x == X_LAST) begin
                dark_x <= '0;
                dark_y <= (dark_y == Y_LAST) ? 9'd0 : dark_y + 9'd1;
            end else begin
                dark_x <= dark_x + 10'd1;
            end
        end
    end

    assign dark_sof = dark_valid && (dark_x == 10'd0) && (dark_y == 9'd0);
    assign dark_eol = dark_valid && (dark_x == X_LAST);
    assign dark_eof = dark_valid && (dark_x == X_LAST) && (dark_y == Y_LAST);

`ifdef DEHAZE_ATMOS_TRACK_EN
    // Strict compare keeps the earliest pixel on ties.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            atm_dark <= '0;
            atm_addr <= '0;
        end else if (start_ok) begin
            atm_dark <= '0;
            atm_addr <= '0;
        end else if (dark_valid && (dark_in > atm_dark)) begin
            atm_dark <= dark_in;
            atm_addr <= AW'(dark_y) * H_AW + AW'(dark_x);
        end
    end
`else
    logic unused_dark_in;
    assign unused_dark_in = ^dark_in;
    assign atm_dark       = '0;
    assign atm_addr       = '0;
`endif

endmodule

// File: tb/tb_dehaze_frame_sched.sv
// Randomized bench for dehaze_frame_sched on a 4x3 frame; expectations come from a
// cycle-indexed event model (read issue times plus fixed latency). Honours DEHAZE_ATMOS_TRACK_EN.
module tb_dehaze_frame_sched;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int N   = H * V;
    localparam int AW  = 4;
    localparam int ML  = 1;
    localparam int DL  = 2;
    localparam int LAT = ML + 1 + DL;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          hold      = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rdata = 24'd0;
    logic [23:0]   picture_data;
    logic [7:0]    dark_in   = 8'd0;
    logic          dark_valid;
    logic [9:0]    dark_x;
    logic [8:0]    dark_y;
    logic          dark_sof;
    logic          dark_eol;
    logic          dark_eof;
    logic          busy;
    logic          done;
    logic [7:0]    atm_dark;
    logic [AW-1:0] atm_addr;

    dehaze_frame_sched #(
        .H_ACT(H), .V_ACT(V), .AW(AW), .MEM_LAT(ML), .DC_LAT(DL)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
        .hold(hold), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .picture_data(picture_data), .dark_in(dark_in), .dark_valid(dark_valid),
        .dark_x(dark_x), .dark_y(dark_y), .dark_sof(dark_sof), .dark_eol(dark_eol),
        .dark_eof(dark_eof), .busy(busy), .done(done), .atm_dark(atm_dark),
        .atm_addr(atm_addr)
    );

    always #5 sys_clk = ~sys_clk;

    logic [23:0] memArr [0:15];

    // Frame buffer with one cycle of read latency; garbage when no read is issued.
    always @(posedge sys_clk) begin
        mem_rdata <= mem_rd_en ? memArr[mem_addr] : 24'($urandom);
    end

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    bit frameOn   = 1'b0;
    int issued    = 0;
    int doneCycle = -1;
    int darkSeen  = 0;
    int atmMax    = 0;
    int atmIdx    = 0;
    int darkTab [0:N-1];
    int picDue[$];
    int picAddr[$];
    int darkDue[$];
    int darkAddr[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clearModel();
        frameOn   = 1'b0;
        issued    = 0;
        doneCycle = -1;
        picDue.delete();
        picAddr.delete();
        darkDue.delete();
        darkAddr.delete();
    endtask

    // One clock: drive inputs after the edge, check mid-cycle, then advance the model.
    task automatic applyStimulus(input logic s, input logic a, input logic h);
        bit eRd;
        bit eDark;
        int ePic;
        int addr;
        int eAtm;
        int eAtmA;
        @(posedge sys_clk);
        #1;
        start = s;
        abort = a;
        hold  = h;
        @(negedge sys_clk);
        cyc++;
`ifdef DEHAZE_ATMOS_TRACK_EN
        eAtm  = atmMax;
        eAtmA = atmIdx;
`else
        eAtm  = 0;
        eAtmA = 0;
`endif
        checkOutput("atm_dark", 32'(atm_dark), 32'(eAtm));
        checkOutput("atm_addr", 32'(atm_addr), 32'(eAtmA));
        eRd = frameOn && (issued < N) && !h;
        if (!a) begin
            checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(eRd));
            if (eRd) checkOutput("mem_addr", 32'(mem_addr), 32'(issued));
        end
        checkOutput("busy", 32'(busy), 32'(frameOn && (cyc != doneCycle)));
        checkOutput("done", 32'(done), 32'(cyc == doneCycle));
        ePic = 0;
        if (picDue.size() > 0 && picDue[0] == cyc) begin
            ePic = int'(memArr[picAddr[0]]);
            void'(picDue.pop_front());
            void'(picAddr.pop_front());
        end
        checkOutput("picture_data", 32'(picture_data), 32'(ePic));
        eDark = (darkDue.size() > 0) && (darkDue[0] == cyc);
        checkOutput("dark_valid", 32'(dark_valid), 32'(eDark));
        if (eDark) begin
            addr = darkAddr[0];
            void'(darkDue.pop_front());
            void'(darkAddr.pop_front());
            checkOutput("dark_x", 32'(dark_x), 32'(addr % H));
            checkOutput("dark_y", 32'(dark_y), 32'(addr / H));
            checkOutput("dark_sof", 32'(dark_sof), 32'(addr == 0));
            checkOutput("dark_eol", 32'(dark_eol), 32'((addr % H) == H - 1));
            checkOutput("dark_eof", 32'(dark_eof), 32'(addr == N - 1));
            if (int'(dark_in) > atmMax) begin
                atmMax = int'(dark_in);
                atmIdx = addr;
            end
            darkSeen++;
        end else begin
            checkOutput("sof_idle", 32'(dark_sof), 32'd0);
            checkOutput("eol_idle", 32'(dark_eol), 32'd0);
            checkOutput("eof_idle", 32'(dark_eof), 32'd0);
            if (!frameOn) begin
                checkOutput("dark_x_idle", 32'(dark_x), 32'd0);
                checkOutput("dark_y_idle", 32'(dark_y), 32'd0);
            end
        end

        if (frameOn && a) begin
            clearModel();
        end else if (frameOn) begin
            if (cyc == doneCycle) begin
                frameOn   = 1'b0;
                doneCycle = -1;
            end else if (eRd) begin
                picDue.push_back(cyc + ML + 1);
                picAddr.push_back(issued);
                darkDue.push_back(cyc + LAT);
                darkAddr.push_back(issued);
                issued++;
                if (issued == N) doneCycle = cyc + LAT + 1;
            end
        end else if (s && !a) begin
            frameOn  = 1'b1;
            issued   = 0;
            darkSeen = 0;
            atmMax   = 0;
            atmIdx   = 0;
            for (int i = 0; i < 16; i++) memArr[i] = 24'($urandom);
        end

        if (darkDue.size() > 0 && darkDue[0] == cyc + 1) dark_in = 8'(darkTab[darkSeen]);
        else dark_in = 8'($urandom);
    endtask

    task automatic resetDut();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        hold      = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_picture_data", 32'(picture_data), 32'd0);
        checkOutput("rst_dark_valid", 32'(dark_valid), 32'd0);
        checkOutput("rst_dark_x", 32'(dark_x), 32'd0);
        checkOutput("rst_dark_y", 32'(dark_y), 32'd0);
        checkOutput("rst_dark_sof", 32'(dark_sof), 32'd0);
        checkOutput("rst_dark_eol", 32'(dark_eol), 32'd0);
        checkOutput("rst_dark_eof", 32'(dark_eof), 32'd0);
        checkOutput("rst_atm_dark", 32'(atm_dark), 32'd0);
        checkOutput("rst_atm_addr", 32'(atm_addr), 32'd0);
        clearModel();
        atmMax = 0;
        atmIdx = 0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // pattern=1: values below 200 except two 200s at raster 5 and 9.
    task automatic fillTab(input bit pattern);
        for (int i = 0; i < N; i++) begin
            darkTab[i] = pattern ? int'($urandom_range(0, 199)) : int'($urandom_range(0, 255));
        end
        if (pattern) begin
            darkTab[5] = 200;
            darkTab[9] = 200;
        end
    endtask

    // holdMode 0: none, 1: RUN cycles 3-5, 2: random. abortAfter: abort once that many reads issued.
    task automatic runFrame(input int holdMode, input int abortAfter, input bit noise);
        int   k;
        logic h;
        logic a;
        logic s;
        k = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        while (frameOn && k < 300) begin
            k++;
            if (holdMode == 1) h = (k >= 3 && k <= 5);
            else if (holdMode == 2) h = ($urandom_range(0, 2) == 0);
            else h = 1'b0;
            a = (abortAfter >= 0) && (issued == abortAfter);
            s = noise && ($urandom_range(0, 3) == 0);
            applyStimulus(s, a, h);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) memArr[i] = 24'($urandom);
        fillTab(1'b0);
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0);

        fillTab(1'b0);
        runFrame(0, -1, 1'b0);

        fillTab(1'b0);
        runFrame(1, -1, 1'b1);

        fillTab(1'b0);
        runFrame(0, 7, 1'b0);
        fillTab(1'b1);
        runFrame(0, -1, 1'b0);
`ifdef DEHAZE_ATMOS_TRACK_EN
        checkOutput("atm_dark_pattern", 32'(atm_dark), 32'd200);
        checkOutput("atm_addr_pattern", 32'(atm_addr), 32'd5);
`else
        checkOutput("atm_dark_pattern", 32'(atm_dark), 32'd0);
        checkOutput("atm_addr_pattern", 32'(atm_addr), 32'd0);
`endif

        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        fillTab(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100 && issued < N; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            fillTab(f[0]);
            runFrame(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dehaze_frame_sched.md
Name: dehaze_frame_sched

Overview:
- Frame scheduler for the static-dehazing dark-channel stage.
- On a start pulse, walks the RGB888 frame buffer in raster order, one read per cycle unless held, and forwards read data to dark_channel.
- Generates valid, coordinate and framing strobes aligned to the dark-channel output (I_dark).
- Reports busy/done; supports abort.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- AW, 19, address width; must satisfy 2^AW >= H_ACT*V_ACT
- MEM_LAT, 1, frame-buffer read latency in cycles (>=1)
- DC_LAT, 2, dark_channel input-to-I_dark latency in cycles (>=0)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start request
- abort  in  1  one-cycle abort request
- hold  in  1  downstream back-pressure; no read is issued in a cycle where hold=1
- mem_rd_en  out  1  frame-buffer read strobe
- mem_addr  out  AW  frame-buffer read address
- mem_rdata  in  24  frame-buffer data, valid MEM_LAT cycles after mem_rd_en
- picture_data  out  24  to dark_channel; registered copy of mem_rdata, 0 when not valid
- dark_in  in  8  I_dark from dark_channel
- dark_valid  out  1  dark_in holds a real pixel this cycle
- dark_x  out  10  column of the current dark pixel
- dark_y  out  9  row of the current dark pixel
- dark_sof  out  1  first dark pixel of the frame
- dark_eol  out  1  last dark pixel of a line
- dark_eof  out  1  last dark pixel of the frame
- busy  out  1  high from the cycle after an accepted start until done/abort
- done  out  1  one-cycle pulse after the last dark pixel
- atm_dark  out  8  frame maximum of dark_in (optional feature)
- atm_addr  out  AW  raster index of atm_dark (optional feature)

Behaviour:
- Reset: one clock, sys_clk; reset asynchronous, active-low on sys_rst_n. All outputs 0, state IDLE, valid pipe cleared, counters 0.
- State IDLE:
  - start=1 and abort=0: go to RUN; clear read address, output coordinates and atm regs.
  - start while not IDLE is ignored.
- State RUN:
  - Each cycle with hold=0: mem_rd_en=1, mem_addr=current index, then index increments.
  - With hold=1: mem_rd_en=0, index unchanged; the bubble propagates as not-valid.
  - Issuing index H_ACT*V_ACT-1: go to DRAIN the next cycle; no further reads.
- State DRAIN: wait until the valid pipe is empty, i.e. the last dark_valid has occurred, then go to DONE.
- State DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Valid pipe:
  - mem_rd_en delayed MEM_LAT cycles gives the picture_data valid; 1 extra register stage for picture_data.
  - That valid delayed DC_LAT further gives dark_valid.
  - Total latency read-issue -> dark_valid = MEM_LAT+1+DC_LAT cycles.
  - Latency is fixed; hold never stalls the pipe, it only inserts gaps.
- Coordinates:
  - Advance on dark_valid only.
  - dark_x wraps from H_ACT-1 to 0 and increments dark_y.
  - dark_y wraps to 0 after V_ACT-1.
  - dark_x/dark_y show the coordinate of the pixel presented in the same cycle.
- Strobes, all qualified by dark_valid:
  - dark_sof when x=0 and y=0.
  - dark_eol when x=H_ACT-1.
  - dark_eof when x=H_ACT-1 and y=V_ACT-1.
- abort, any non-IDLE state:
  - Next cycle: state IDLE, busy=0, valid pipe flushed, dark_valid=0, counters 0, no done.
  - abort in IDLE with simultaneous start: abort wins; stay IDLE.
- Reset mid-frame: identical to power-up; no done.
- Back-to-back frames: start in the cycle done=1 is ignored (state is still DONE); start is accepted in IDLE from the next cycle.
- Widths: index compare in AW bits; coordinate counters never exceed H_ACT-1/V_ACT-1.

Optional Feature:
- Macro: DEHAZE_ATMOS_TRACK_EN.
- Defined:
  - On each dark_valid with dark_in > atm_dark (strict), update atm_dark=dark_in and atm_addr=dark_y*H_ACT+dark_x.
  - Ties keep the earliest pixel.
  - Both cleared on accepted start; held after done until the next start.
- Undefined: atm_dark and atm_addr tied to 0; no comparator logic.

Test Plan:
- H_ACT=4, V_ACT=3, MEM_LAT=1, DC_LAT=2, no hold, start once -> addresses 0..11 on consecutive cycles; first dark_valid 4 cycles after first mem_rd_en; 12 dark_valid cycles; dark_eol at x=3 thrice; dark_eof with (3,2); done 1 cycle after eof; busy low afterwards.
- Same config, hold=1 for cycles 3-5 of RUN -> 3 gaps in mem_rd_en and in dark_valid, total dark_valid count still 12, coordinates continuous.
- abort mid-frame after address 6 -> next cycle busy=0, dark_valid=0, no done; a following start restarts at address 0 with dark_sof on the first output.
- start asserted while busy and start+abort together in IDLE -> both ignored; address sequence unaffected.
- sys_rst_n low for 1 cycle mid-DRAIN -> all outputs 0 immediately, no done.
- With DEHAZE_ATMOS_TRACK_EN, dark_in pattern where 200 appears at raster 5 and 9 -> atm_dark=200, atm_addr=5; without macro both 0.
